// File: rtl/elastic_buf_hbw.sv
// Single-entry half-bandwidth elastic buffer: registered valid/ready on both sides.
// Optional statistics counters are enabled with the ELASTIC_BUF_STATS_EN macro.
module elastic_buf_hbw #(
  parameter int DATA_W = 8
`ifdef ELASTIC_BUF_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_srdy,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_rrdy,
  input  logic              out_rrdy,
  output logic              out_srdy,
  output logic [DATA_W-1:0] out_data
`ifdef ELASTIC_BUF_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_in_cnt,
  output logic [CNT_W-1:0]  stat_out_cnt,
  output logic [CNT_W-1:0]  stat_stall_cnt
`endif
);

  logic              full_q;
  logic [DATA_W-1:0] data_q;
  logic              accept;
  logic              pop;

  // Accept needs an empty buffer and pop needs a full one, so they never coincide.
  assign accept = in_srdy & ~full_q;
  assign pop    = full_q & out_rrdy;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
    end else if (accept) begin
      full_q <= 1'b1;
    end else if (pop) begin
      full_q <= 1'b0;
    end
  end

  // NOTE: the data register is reset too, so out_data reads zero during and after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (accept) begin
      data_q <= in_data;
    end
  end

  assign in_rrdy  = ~full_q;
  assign out_srdy = full_q;
  assign out_data = data_q;

`ifdef ELASTIC_BUF_STATS_EN
  logic stall;

  assign stall = in_srdy & full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_in_cnt    <= '0;
      stat_out_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (accept) stat_in_cnt    <= stat_in_cnt + 1'b1;
      if (pop)    stat_out_cnt   <= stat_out_cnt + 1'b1;
      if (stall)  stat_stall_cnt <= stat_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_elastic_buf_hbw.sv
// Self-checking bench for elastic_buf_hbw: directed steps then random traffic
// checked against a one-deep queue model.
module tb_elastic_buf_hbw;

  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              in_srdy;
  logic [DATA_W-1:0] in_data;
  logic              in_rrdy;
  logic              out_rrdy;
  logic              out_srdy;
  logic [DATA_W-1:0] out_data;
`ifdef ELASTIC_BUF_STATS_EN
  logic [15:0]       stat_in_cnt;
  logic [15:0]       stat_out_cnt;
  logic [15:0]       stat_stall_cnt;
`endif

  elastic_buf_hbw #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_srdy  (in_srdy),
    .in_data  (in_data),
    .in_rrdy  (in_rrdy),
    .out_rrdy (out_rrdy),
    .out_srdy (out_srdy),
    .out_data (out_data)
`ifdef ELASTIC_BUF_STATS_EN
    ,
    .stat_in_cnt    (stat_in_cnt),
    .stat_out_cnt   (stat_out_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model: a queue of capacity one plus the last accepted word.
  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] model_last = '0;
  int                model_in    = 0;
  int                model_out   = 0;
  int                model_stall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_srdy"}, 32'(out_srdy), 32'(model_q.size() != 0));
    check({tag, ".in_rrdy"},  32'(in_rrdy),  32'(model_q.size() == 0));
    check({tag, ".out_data"}, 32'(out_data), 32'(model_last));
  endtask

  task automatic model_reset();
    model_q.delete();
    model_last = '0;
  endtask

  // One clock with the given inputs; model advances by the handshake rules.
  task automatic cycle(input string tag, input logic s, input logic [DATA_W-1:0] d,
                       input logic r);
    in_srdy  = s;
    in_data  = d;
    out_rrdy = r;
    if (s && model_q.size() != 0) model_stall++;
    if (s && model_q.size() == 0) begin
      model_q.push_back(d);
      model_last = d;
      model_in++;
    end else if (r && model_q.size() != 0) begin
      void'(model_q.pop_front());
      model_out++;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_srdy  = 1'b0;
    in_data  = '0;
    out_rrdy = 1'b0;

    // Reset held across edges, inputs quiet.
    #2;
    check_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs("reset_hold");
    rst_n = 1'b1;
    #1;
    check_outputs("release");
    @(posedge clk);
    #1;
    check_outputs("release_idle");

    // Directed handshake steps.
    cycle("write_empty", 1'b1, 8'hA5, 1'b0);
    cycle("write_full",  1'b1, 8'h5A, 1'b0);
    cycle("full_hold",   1'b0, 8'h00, 1'b0);
    cycle("read",        1'b0, 8'h00, 1'b1);
    cycle("read_empty",  1'b0, 8'h00, 1'b1);
    cycle("simul_empty", 1'b1, 8'h3C, 1'b1);
    cycle("simul_full",  1'b1, 8'h77, 1'b1);
    cycle("refill",      1'b1, 8'h3C, 1'b0);

    // Reset asserted between edges while full and offered a new word.
    in_srdy  = 1'b1;
    in_data  = 8'hFF;
    out_rrdy = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("mid_reset");
    @(posedge clk);
    #1;
    check_outputs("mid_reset_edge");
    in_srdy = 1'b0;
    rst_n   = 1'b1;
    #1;
    check_outputs("mid_release");
    cycle("post_reset", 1'b0, 8'h00, 1'b0);

`ifdef ELASTIC_BUF_STATS_EN
    // The mid-operation reset cleared the counters.
    model_in    = 0;
    model_out   = 0;
    model_stall = 0;
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle("random", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

`ifdef ELASTIC_BUF_STATS_EN
    check("stat_in_cnt",    32'(stat_in_cnt),    32'(model_in[15:0]));
    check("stat_out_cnt",   32'(stat_out_cnt),   32'(model_out[15:0]));
    check("stat_stall_cnt", 32'(stat_stall_cnt), 32'(model_stall[15:0]));
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/elastic_buf_hbw.md
Name: elastic_buf_hbw

Overview:
- Single-entry, half-bandwidth elastic buffer (skid-free pipeline register) with a valid/ready handshake on both sides. Upstream is the sender (srdy = valid), downstream is the receiver (rrdy = ready).
- Breaks combinational ready/valid timing paths between pipeline stages: out_srdy and in_rrdy depend on registered state only.
- Throughput is at most one word every two cycles.

Parameters:
- DATA_W, 8, width of the data path.
- CNT_W, 16, width of the statistics counters (used only when ELASTIC_BUF_STATS_EN is defined).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_srdy  input  1  upstream data valid.
- in_data  input  DATA_W  upstream data.
- in_rrdy  output  1  buffer can accept a word.
- out_rrdy  input  1  downstream ready to take a word.
- out_srdy  output  1  buffer holds a valid word.
- out_data  output  DATA_W  held word.
- Ports present only with ELASTIC_BUF_STATS_EN: stat_in_cnt, stat_out_cnt, stat_stall_cnt, each output CNT_W (see Optional Feature).

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- State: full_q (1 bit) and data_q (DATA_W bits).
- Reset (asynchronous, takes effect immediately on rst_n low): full_q=0, data_q=0. Outputs during reset: out_srdy=0, out_data=0, in_rrdy=1.
- Combinational outputs: in_rrdy = ~full_q; out_srdy = full_q; out_data = data_q. No combinational path from any input to any output.
- Accept: on a clk rising edge where in_srdy & in_rrdy, set full_q<=1 and data_q<=in_data. Latency from accept to out_srdy=1 is one cycle.
- Pop: on a clk rising edge where out_srdy & out_rrdy, set full_q<=0. data_q retains its old value; out_data is don't-care-but-stable while empty.
- Full: in_rrdy=0, and in_srdy/in_data are ignored. The word is not overwritten and not queued.
- Empty: out_rrdy is ignored and no pop occurs.
- Simultaneous in_srdy and out_rrdy: accept and pop can never occur in the same cycle (accept requires empty, pop requires full).
  - When empty, the word is accepted.
  - When full, the word is popped and the input stalls until the next cycle.
- data_q stays stable for the whole time out_srdy=1 until the pop.
- Reset asserted mid-operation: any held word is discarded. After rst_n deasserts, the buffer is empty.
- No X propagation: in_data is sampled only on accept.

Optional Feature:
- Macro: ELASTIC_BUF_STATS_EN.
- Defined: adds three CNT_W-bit counters as output ports. All reset to 0 asynchronously and wrap modulo 2^CNT_W.
  - stat_in_cnt: +1 per accept.
  - stat_out_cnt: +1 per pop.
  - stat_stall_cnt: +1 per cycle with in_srdy=1 and in_rrdy=0.
- Not defined: the counters and their ports do not exist. Datapath behaviour is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 -> out_srdy=0, out_data=8'h00, in_rrdy=1. Release -> state unchanged.
- Write when empty: in_srdy=1, in_data=8'hA5 for one cycle -> after the edge, out_srdy=1, out_data=8'hA5, in_rrdy=0.
- Write while full: in_srdy=1, in_data=8'h5A -> not accepted; out_data stays 8'hA5, in_rrdy stays 0 (stat_stall_cnt +1 if enabled).
- Read: out_rrdy=1 for one cycle -> after the edge, out_srdy=0, in_rrdy=1. A following out_rrdy while empty causes no change.
- Simultaneous while empty: in_srdy=1, in_data=8'h3C, out_rrdy=1 -> 8'h3C accepted, out_srdy=1 next cycle, no pop that cycle.
- Reset mid-operation: buffer full with 8'h3C, in_srdy=1, in_data=8'hFF, then rst_n=0 between edges -> out_srdy=0 and out_data=8'h00 immediately; buffer empty after release; 8'hFF never appears.
